pid_stage_fifo: RTL and testbench



---
 rtl/pid_pkg.sv | 14 +
 rtl/pid_fifo_mem.sv | 36 +++
 rtl/pid_stage_fifo.sv | 144 ++++++++++++++
 tb/tb_pid_stage_fifo.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared constants for the PID pipeline stages.
// Config addresses and FIFO overflow policy encodings.
package pid_pkg;

  localparam logic [15:0] ADDR_FIFO_MODE    = 16'h0040;
  localparam logic [15:0] ADDR_FIFO_FLUSH   = 16'h0041;
  localparam logic [15:0] ADDR_FIFO_CLR_CNT = 16'h0042;

  typedef enum logic {
    FIFO_DROP_NEW = 1'b0,
    FIFO_DROP_OLD = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/pid_fifo_mem.sv
// Dual-port storage for the stage FIFO.
// Synchronous write; read data lands in a registered output stage.
module pid_fifo_mem #(
  parameter int W     = 133,
  parameter int DEPTH = 16,
  parameter int W_PTR = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [W_PTR-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             re_i,
  input  logic [W_PTR-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Same-edge writes are not visible here: only older entries load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pid_stage_fifo.sv
// Elastic valid/ready buffer between PID stages with overflow policy,
// per-channel saturating drop counters and flush.
module pid_stage_fifo
  import pid_pkg::*;
#(
  parameter int N_CHAN    = 5,
  parameter int W_CHAN    = 5,
  parameter int W_DATA    = 128,
  parameter int DEPTH     = 16,
  parameter int W_PTR     = 4,
  parameter int W_CNT     = 16,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  input  logic                 rdy_in,
  input  logic [W_CHAN-1:0]    cnt_sel,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out,
  output logic [W_PTR:0]       level_out,
  output logic                 full_out,
  output logic [W_CNT-1:0]     drop_cnt_out
);

  localparam logic [W_PTR:0]    FULL_LVL = (W_PTR+1)'(DEPTH);
  localparam logic [W_CHAN-1:0] NCH      = W_CHAN'(N_CHAN);

  fifo_mode_e          mode_q;
  logic [W_PTR-1:0]    wr_ptr_q, wr_ptr_d;
  logic [W_PTR-1:0]    rd_ptr_q, rd_ptr_d;
  logic [W_PTR:0]      lvl_q, lvl_d, old_left;
  logic                dv_q, dv_d;
  logic                cfg_mode, cfg_flush, cfg_clr;
  logic                push_req, pop, full;
  logic                drop_new, drop_old, wr, rd_adv;
  logic [N_CHAN-1:0]   clr_v, inc_v;
  logic [W_CNT-1:0]    cnt_q [N_CHAN];
  logic [W_CHAN+W_DATA-1:0] rdata;
  logic                unused_wr_data;

  assign cfg_mode  = wr_en && wr_addr == W_WR_ADDR'(ADDR_FIFO_MODE);
  assign cfg_flush = wr_en && wr_addr == W_WR_ADDR'(ADDR_FIFO_FLUSH);
  assign cfg_clr   = wr_en && wr_addr == W_WR_ADDR'(ADDR_FIFO_CLR_CNT);
  assign unused_wr_data = ^wr_data[W_WR_DATA-1:1];

  assign push_req = dv_in && chan_in < NCH && !cfg_flush;
  assign pop      = dv_q && rdy_in;
  assign full     = lvl_q == FULL_LVL;
  assign drop_new = push_req && full && !pop
                    && mode_q == FIFO_DROP_NEW;
  assign drop_old = push_req && full && !pop
                    && mode_q == FIFO_DROP_OLD;
  assign wr       = push_req && !drop_new;
  assign rd_adv   = pop || drop_old;
  assign old_left = lvl_q - (W_PTR+1)'(rd_adv);

  // Output is valid only if an entry stored before this edge remains.
  always_comb begin
    wr_ptr_d = wr_ptr_q + W_PTR'(wr);
    rd_ptr_d = rd_ptr_q + W_PTR'(rd_adv);
    lvl_d    = old_left + (W_PTR+1)'(wr);
    dv_d     = old_left != '0;
    if (cfg_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
      dv_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      dv_q     <= 1'b0;
      mode_q   <= FIFO_DROP_NEW;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      dv_q     <= dv_d;
      if (cfg_mode) mode_q <= fifo_mode_e'(wr_data[0]);
    end
  end

  pid_fifo_mem #(
    .W     (W_CHAN + W_DATA),
    .DEPTH (DEPTH),
    .W_PTR (W_PTR)
  ) u_mem (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .we_i    (wr),
    .waddr_i (wr_ptr_q),
    .wdata_i ({chan_in, data_in}),
    .re_i    (dv_d),
    .raddr_i (rd_ptr_d),
    .rdata_o (rdata)
  );

  // The discarded oldest entry is the one on the output register.
  always_comb begin
    clr_v        = '0;
    inc_v        = '0;
    drop_cnt_out = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      clr_v[i] = cfg_clr && wr_chan == W_WR_CHAN'(i);
      inc_v[i] = (drop_new && chan_in == W_CHAN'(i))
                 || (drop_old && chan_out == W_CHAN'(i));
      if (cnt_sel == W_CHAN'(i)) drop_cnt_out = cnt_q[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < N_CHAN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (clr_v[i]) begin
          cnt_q[i] <= '0;
        end else if (inc_v[i] && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign {chan_out, data_out} = rdata;
  assign dv_out    = dv_q;
  assign level_out = lvl_q;
  assign full_out  = full;

endmodule

// File: tb/tb_pid_stage_fifo.sv
// Randomized and directed bench for pid_stage_fifo against a queue model.
module tb_pid_stage_fifo;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         dv_in = 1'b0;
  logic [4:0]   chan_in = '0;
  logic [127:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic [15:0]  wr_addr = '0;
  logic [15:0]  wr_chan = '0;
  logic [47:0]  wr_data = '0;
  logic         rdy_in = 1'b0;
  logic [4:0]   cnt_sel = '0;
  logic         dv_out;
  logic [4:0]   chan_out;
  logic [127:0] data_out;
  logic [4:0]   level_out;
  logic         full_out;
  logic [15:0]  drop_cnt_out;

  pid_stage_fifo dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .dv_in        (dv_in),
    .chan_in      (chan_in),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_chan      (wr_chan),
    .wr_data      (wr_data),
    .rdy_in       (rdy_in),
    .cnt_sel      (cnt_sel),
    .dv_out       (dv_out),
    .chan_out     (chan_out),
    .data_out     (data_out),
    .level_out    (level_out),
    .full_out     (full_out),
    .drop_cnt_out (drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]   ch;
    logic [127:0] d;
    int           t;
  } ent_t;

  ent_t q[$];
  int   mcnt[5];
  bit   mmode;
  bit   mdv;
  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    foreach (mcnt[i]) mcnt[i] = 0;
    mmode = 1'b0;
    mdv   = 1'b0;
  endfunction

  function automatic void bump(int c);
    if (mcnt[c] < 65535) mcnt[c]++;
  endfunction

  // Queue semantics: an entry becomes visible one edge after it is stored.
  function automatic void model_update();
    bit   pop, flush, preq;
    ent_t e;
    edge_n++;
    pop   = mdv && rdy_in;
    flush = wr_en && wr_addr == 16'h0041;
    preq  = dv_in && chan_in < 5 && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) e = q.pop_front();
      if (preq) begin
        if (q.size() == 16 && !mmode) begin
          bump(int'(chan_in));
        end else begin
          if (q.size() == 16) begin
            e = q.pop_front();
            bump(int'(e.ch));
          end
          e.ch = chan_in;
          e.d  = data_in;
          e.t  = edge_n;
          q.push_back(e);
        end
      end
    end
    if (wr_en && wr_addr == 16'h0042 && wr_chan < 5) mcnt[wr_chan] = 0;
    if (wr_en && wr_addr == 16'h0040) mmode = wr_data[0];
    mdv = 1'b0;
    if (q.size() > 0) mdv = q[0].t < edge_n;
  endfunction

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("dv_out", dv_out, mdv);
      chk("level", level_out, q.size());
      chk("full", full_out, q.size() == 16);
      chk("drop_cnt", drop_cnt_out, cnt_sel < 5 ? mcnt[cnt_sel] : 0);
      if (mdv) begin
        chk("chan", chan_out, q[0].ch);
        chk("data", data_out, q[0].d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
    model_update();
    @(negedge clk_in);
    #1;
  endtask

  task automatic push(input logic [4:0] ch, input logic [127:0] d);
    dv_in   = 1'b1;
    chan_in = ch;
    data_in = d;
    cyc();
    dv_in   = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] a, input logic [15:0] c,
                     input logic [47:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_chan = c;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic fill(input int n);
    rdy_in = 1'b0;
    for (int i = 0; i < n; i++) push(5'(i % 5), 128'(i));
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_in = 1'b0;
    dv_in  = 1'b0;
    wr_en  = 1'b0;
    rdy_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  task automatic drain_chk(input string nm, input bit ovf_tail);
    logic [127:0] exp;
    rdy_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp = ovf_tail ? (k < 15 ? 128'(k + 1) : 128'd99) : 128'(k);
      chk({nm, "_dv"}, dv_out, 1'b1);
      chk(nm, data_out, exp);
      cyc();
    end
    chk({nm, "_empty"}, level_out, 0);
  endtask

  initial begin
    int r;
    model_reset();
    repeat (3) @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    chk_en = 1'b1;
    chk("rst_dv", dv_out, 0);
    chk("rst_lvl", level_out, 0);
    chk("rst_full", full_out, 0);
    chk("rst_cnt", drop_cnt_out, 0);
    chk("rst_chan", chan_out, 0);
    chk("rst_data", data_out, 0);

    rdy_in = 1'b1;
    push(5'd2, 128'h1234);
    chk("t1_lvl1", level_out, 1);
    chk("t1_dv0", dv_out, 0);
    cyc();
    chk("t1_dv", dv_out, 1);
    chk("t1_chan", chan_out, 2);
    chk("t1_data", data_out, 128'h1234);
    cyc();
    chk("t1_lvl0", level_out, 0);
    chk("t1_dvoff", dv_out, 0);

    fill(16);
    chk("t2_full", full_out, 1);
    chk("t2_lvl", level_out, 16);
    drain_chk("t2_seq", 1'b0);

    fill(16);
    cnt_sel = 5'd3;
    push(5'd3, 128'd99);
    chk("t3_cnt3", drop_cnt_out, 1);
    chk("t3_lvl", level_out, 16);
    drain_chk("t3_seq", 1'b0);

    do_reset();
    cfg(16'h0040, 16'd0, 48'd1);
    fill(16);
    push(5'd3, 128'd99);
    cnt_sel = 5'd0;
    #1;
    chk("t4_cnt0", drop_cnt_out, 1);
    cnt_sel = 5'd3;
    #1;
    chk("t4_cnt3", drop_cnt_out, 0);
    drain_chk("t4_seq", 1'b1);

    do_reset();
    fill(16);
    rdy_in = 1'b1;
    push(5'd1, 128'd55);
    chk("t5_lvl", level_out, 16);
    chk("t5_head", data_out, 1);
    cnt_sel = 5'd1;
    #1;
    chk("t5_cnt1", drop_cnt_out, 0);
    rdy_in = 1'b0;
    push(5'd7, 128'd77);
    chk("t5_lvl7", level_out, 16);
    cnt_sel = 5'd2;
    #1;
    chk("t5_cnt2", drop_cnt_out, 0);

    do_reset();
    fill(9);
    chk("t6_lvl9", level_out, 9);
    rdy_in  = 1'b1;
    dv_in   = 1'b1;
    chan_in = 5'd1;
    data_in = 128'd5;
    chk_en  = 1'b0;
    rst_in  = 1'b0;
    #1;
    chk("t6_dv", dv_out, 0);
    chk("t6_lvl", level_out, 0);
    chk("t6_full", full_out, 0);
    chk("t6_chan", chan_out, 0);
    chk("t6_data", data_out, 0);
    chk("t6_cnt", drop_cnt_out, 0);
    do_reset();

    fill(5);
    chk("t7_lvl5", level_out, 5);
    dv_in   = 1'b1;
    chan_in = 5'd2;
    data_in = 128'd42;
    cfg(16'h0041, 16'd0, 48'd0);
    dv_in   = 1'b0;
    chk("t7_lvl0", level_out, 0);
    chk("t7_dv0", dv_out, 0);
    cyc();
    chk("t7_lvl_after", level_out, 0);
    chk("t7_dv_after", dv_out, 0);

    for (int n = 0; n < 4000; n++) begin
      dv_in   = $urandom_range(0, 3) != 0;
      chan_in = 5'($urandom_range(0, 6));
      data_in = {$urandom, $urandom, $urandom, $urandom};
      if (((n / 400) % 2) == 1) rdy_in = $urandom_range(0, 3) == 0;
      else rdy_in = $urandom_range(0, 3) != 0;
      cnt_sel = 5'($urandom_range(0, 7));
      wr_en   = $urandom_range(0, 24) == 0;
      r = int'($urandom_range(0, 9));
      if (r < 4) wr_addr = 16'h0040;
      else if (r == 4) wr_addr = 16'h0041;
      else if (r < 9) wr_addr = 16'h0042;
      else wr_addr = 16'h0043;
      wr_chan = 16'($urandom_range(0, 6));
      wr_data = 48'($urandom);
      cyc();
    end
    wr_en  = 1'b0;
    dv_in  = 1'b0;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
